wb_queue: RTL

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 107 ++++++++++
 1 files changed

// File: rtl/wb_queue.sv
// wb_queue: pending-writeback FIFO merging load and ALU results into one register-file write port.
// Define WB_QUEUE_FWD_EN to build the forwarding search over queued and outgoing results.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [4:0]               ld_rd,
    input  logic [31:0]              ld_data,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    input  logic                     wb_stall,
    output logic                     reg_write,
    output logic [4:0]               waddr,
    output logic [31:0]              wdata,
    input  logic [4:0]               fwd_addr,
    output logic                     fwd_hit,
    output logic [31:0]              fwd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] rp;
    logic [PW-1:0] wp;
    logic          full;
    logic          push_ld;
    logic          push_alu;
    logic          enq;
    logic          pop;
    logic [4:0]    in_rd;
    logic [31:0]   in_data;

    // A full queue refuses input even when the head leaves this cycle.
    assign full      = count == CW'(DEPTH);
    assign ld_ready  = !full;
    assign alu_ready = !full && !ld_valid;
    assign push_ld   = ld_valid && ld_ready;
    assign push_alu  = alu_valid && alu_ready;
    assign in_rd     = ld_valid ? ld_rd : alu_rd;
    assign in_data   = ld_valid ? ld_data : alu_data;
    assign enq       = (push_ld || push_alu) && in_rd != 5'd0;
    assign pop       = !wb_stall && count != '0;

    always_ff @(posedge clk) begin
        if (enq) begin
            rd_mem[wp]   <= in_rd;
            data_mem[wp] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rp        <= '0;
            wp        <= '0;
            count     <= '0;
            reg_write <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
        end else begin
            wp        <= enq ? wp + PW'(1) : wp;
            rp        <= pop ? rp + PW'(1) : rp;
            count     <= count + CW'(enq) - CW'(pop);
            reg_write <= pop;
            if (pop) begin
                waddr <= rd_mem[rp];
                wdata <= data_mem[rp];
            end
        end
    end

`ifdef WB_QUEUE_FWD_EN
    logic [PW-1:0] idx;
    logic          q_hit;
    logic [31:0]   q_data;

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        idx    = rp;
        q_hit  = 1'b0;
        q_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rp + PW'(k);
            if (CW'(k) < count && rd_mem[idx] == fwd_addr) begin
                q_hit  = 1'b1;
                q_data = data_mem[idx];
            end
        end
    end

    assign fwd_hit  = fwd_addr != 5'd0 && (q_hit || (reg_write && waddr == fwd_addr));
    assign fwd_data = !fwd_hit ? '0 : q_hit ? q_data : wdata;
`else
    logic unused_fwd;

    assign unused_fwd = ^fwd_addr;
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
`endif

endmodule
